// File: rtl/taxi_ram_1rw_arb_resp_fifo.sv
// Two-entry in-order register FIFO. The head register drives the output directly,
// so the consumer sees no combinational path from push to data.
module taxi_ram_1rw_arb_resp_fifo #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head_data,
    output logic              head_valid,
    output logic [1:0]        occ
);

    logic [DATA_W-1:0] head_q, head_d;
    logic [DATA_W-1:0] tail_q, tail_d;
    logic [1:0]        occ_q, occ_d;
    logic              pop_ok;
    logic              push_ok;

    assign pop_ok  = pop && (occ_q != 2'd0);
    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign push_ok = push && ((occ_q != 2'd2) || pop_ok);

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        unique case ({push_ok, pop_ok})
            2'b10: begin
                if (occ_q == 2'd0) begin
                    head_d = push_data;
                end else begin
                    tail_d = push_data;
                end
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                head_d = tail_q;
                occ_d  = occ_q - 2'd1;
            end
            2'b11: begin
                if (occ_q == 2'd1) begin
                    head_d = push_data;
                end else begin
                    head_d = tail_q;
                    tail_d = push_data;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= 2'd0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
        end
    end

    assign head_data  = head_q;
    assign head_valid = (occ_q != 2'd0);
    assign occ        = occ_q;

endmodule

// File: rtl/taxi_ram_1rw_arb.sv
// Round-robin arbiter between a write and a read command stream onto one single-port RAM,
// with read responses returned through a credit-protected two-entry FIFO.
module taxi_ram_1rw_arb #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int STRB_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,

    input  logic [ADDR_W-1:0] wr_cmd_addr,
    input  logic [DATA_W-1:0] wr_cmd_data,
    input  logic [STRB_W-1:0] wr_cmd_strb,
    input  logic              wr_cmd_valid,
    output logic              wr_cmd_ready,
    output logic              wr_done,

    input  logic [ADDR_W-1:0] rd_cmd_addr,
    input  logic              rd_cmd_valid,
    output logic              rd_cmd_ready,
    output logic [DATA_W-1:0] rd_resp_data,
    output logic              rd_resp_valid,
    input  logic              rd_resp_ready,

    output logic              ram_en,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wr_en,
    output logic [DATA_W-1:0] ram_wr_data,
    output logic [STRB_W-1:0] ram_wr_strb,
    input  logic [DATA_W-1:0] ram_rd_data
);

    localparam logic GRANT_WRITE = 1'b0;
    localparam logic GRANT_READ  = 1'b1;

    logic       last_grant_q, last_grant_d;
    logic       inflight_q, inflight_d;
    logic       wr_done_q, wr_done_d;

    logic       gnt_wr;
    logic       gnt_rd;
    logic       rd_eligible;
    logic       resp_pop;
    logic [1:0] fifo_occ;
    logic [2:0] credit_used;

    assign resp_pop = rd_resp_valid && rd_resp_ready;

    // Entries held plus the read whose data lands next cycle, less what leaves now.
    assign credit_used = {1'b0, fifo_occ} + {2'b00, inflight_q} - {2'b00, resp_pop};
    assign rd_eligible = rd_cmd_valid && (credit_used < 3'd2);

    always_comb begin
        gnt_wr = 1'b0;
        gnt_rd = 1'b0;
        if (wr_cmd_valid && rd_eligible) begin
            if (last_grant_q == GRANT_READ) begin
                gnt_wr = 1'b1;
            end else begin
                gnt_rd = 1'b1;
            end
        end else if (wr_cmd_valid) begin
            gnt_wr = 1'b1;
        end else if (rd_eligible) begin
            gnt_rd = 1'b1;
        end
    end

    always_comb begin
        last_grant_d = last_grant_q;
        if (gnt_wr) begin
            last_grant_d = GRANT_WRITE;
        end else if (gnt_rd) begin
            last_grant_d = GRANT_READ;
        end
        inflight_d = gnt_rd;
        wr_done_d  = gnt_wr;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= GRANT_READ;
            inflight_q   <= 1'b0;
            wr_done_q    <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            inflight_q   <= inflight_d;
            wr_done_q    <= wr_done_d;
        end
    end

    assign wr_cmd_ready = gnt_wr;
    assign rd_cmd_ready = gnt_rd;
    assign wr_done      = wr_done_q;

    assign ram_en      = gnt_wr || gnt_rd;
    assign ram_wr_en   = gnt_wr;
    assign ram_addr    = gnt_wr ? wr_cmd_addr : rd_cmd_addr;
    assign ram_wr_data = wr_cmd_data;
    assign ram_wr_strb = wr_cmd_strb;

    taxi_ram_1rw_arb_resp_fifo #(
        .DATA_W (DATA_W)
    ) u_resp_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (inflight_q),
        .push_data  (ram_rd_data),
        .pop        (resp_pop),
        .head_data  (rd_resp_data),
        .head_valid (rd_resp_valid),
        .occ        (fifo_occ)
    );

endmodule

// File: tb/tb_taxi_ram_1rw_arb.sv
// Directed bench for taxi_ram_1rw_arb with a behavioural single-port RAM attached.
module tb_taxi_ram_1rw_arb;

    logic        clk;
    logic        rst;
    logic [15:0] wr_cmd_addr;
    logic [15:0] wr_cmd_data;
    logic [1:0]  wr_cmd_strb;
    logic        wr_cmd_valid;
    logic        wr_cmd_ready;
    logic        wr_done;
    logic [15:0] rd_cmd_addr;
    logic        rd_cmd_valid;
    logic        rd_cmd_ready;
    logic [15:0] rd_resp_data;
    logic        rd_resp_valid;
    logic        rd_resp_ready;
    logic        ram_en;
    logic [15:0] ram_addr;
    logic        ram_wr_en;
    logic [15:0] ram_wr_data;
    logic [1:0]  ram_wr_strb;
    logic [15:0] ram_rd_data;

    logic [15:0] mem [0:65535];

    int checks = 0;
    int errors = 0;

    taxi_ram_1rw_arb #(
        .ADDR_W (16),
        .DATA_W (16),
        .STRB_W (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .wr_cmd_addr   (wr_cmd_addr),
        .wr_cmd_data   (wr_cmd_data),
        .wr_cmd_strb   (wr_cmd_strb),
        .wr_cmd_valid  (wr_cmd_valid),
        .wr_cmd_ready  (wr_cmd_ready),
        .wr_done       (wr_done),
        .rd_cmd_addr   (rd_cmd_addr),
        .rd_cmd_valid  (rd_cmd_valid),
        .rd_cmd_ready  (rd_cmd_ready),
        .rd_resp_data  (rd_resp_data),
        .rd_resp_valid (rd_resp_valid),
        .rd_resp_ready (rd_resp_ready),
        .ram_en        (ram_en),
        .ram_addr      (ram_addr),
        .ram_wr_en     (ram_wr_en),
        .ram_wr_data   (ram_wr_data),
        .ram_wr_strb   (ram_wr_strb),
        .ram_rd_data   (ram_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered-read RAM; read data holds until the next read.
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_wr_en) begin
                if (ram_wr_strb[0]) mem[ram_addr][7:0]  <= ram_wr_data[7:0];
                if (ram_wr_strb[1]) mem[ram_addr][15:8] <= ram_wr_data[15:8];
            end else begin
                ram_rd_data <= mem[ram_addr];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        wr_cmd_valid = 1'b0;
        wr_cmd_addr  = '0;
        wr_cmd_data  = '0;
        wr_cmd_strb  = '0;
        rd_cmd_valid = 1'b0;
        rd_cmd_addr  = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Starts just after a falling edge; returns just after the next one.
    task automatic do_write(input logic [15:0] a, input logic [15:0] d, input logic [1:0] s,
                            input string tag);
        wr_cmd_valid = 1'b1;
        wr_cmd_addr  = a;
        wr_cmd_data  = d;
        wr_cmd_strb  = s;
        #1;
        chk({tag, "_wr_rdy"}, wr_cmd_ready, 1);
        @(negedge clk);
        wr_cmd_valid = 1'b0;
        #1;
        chk({tag, "_wr_done"}, wr_done, 1);
    endtask

    task automatic read_expect(input logic [15:0] a, input logic [15:0] exp, input string tag);
        rd_cmd_valid = 1'b1;
        rd_cmd_addr  = a;
        #1;
        chk({tag, "_rd_rdy"}, rd_cmd_ready, 1);
        @(negedge clk);
        rd_cmd_valid = 1'b0;
        #1;
        chk({tag, "_early"}, rd_resp_valid, 0);
        @(negedge clk);
        #1;
        chk({tag, "_valid"}, rd_resp_valid, 1);
        chk({tag, "_data"}, rd_resp_data, exp);
        @(negedge clk);
        #1;
        chk({tag, "_popped"}, rd_resp_valid, 0);
    endtask

    function automatic logic [15:0] pat(input int i);
        return 16'h5A00 + 16'(i * 273);
    endfunction

    logic [15:0] t4_addr [5];
    logic [15:0] t4_exp  [5];
    int          wd_cnt;
    int          rsp_cnt;
    int          k;
    int          got;

    initial begin
        rd_resp_ready = 1'b1;
        do_reset();
        #1;
        chk("rst_resp_valid", rd_resp_valid, 0);
        chk("rst_wr_done", wr_done, 0);
        chk("rst_ram_en", ram_en, 0);
        chk("rst_rd_rdy", rd_cmd_ready, 0);

        // Basic write then read-back
        wr_cmd_valid = 1'b1;
        wr_cmd_addr  = 16'h0010;
        wr_cmd_data  = 16'hA5A5;
        wr_cmd_strb  = 2'b11;
        #1;
        chk("w1_rdy", wr_cmd_ready, 1);
        chk("w1_ram_en", ram_en, 1);
        chk("w1_ram_wr_en", ram_wr_en, 1);
        chk("w1_ram_addr", ram_addr, 16'h0010);
        chk("w1_ram_data", ram_wr_data, 16'hA5A5);
        @(negedge clk);
        wr_cmd_valid = 1'b0;
        #1;
        chk("w1_done", wr_done, 1);
        chk("w1_rd_idle", rd_cmd_ready, 0);
        @(negedge clk);
        #1;
        chk("w1_done_pulse", wr_done, 0);
        read_expect(16'h0010, 16'hA5A5, "r1");

        // Byte-strobe merge, then a zero-strobe write that must not change data
        do_write(16'h0020, 16'hFFFF, 2'b11, "w2a");
        do_write(16'h0020, 16'h1200, 2'b10, "w2b");
        read_expect(16'h0020, 16'h12FF, "r2");
        do_write(16'h0020, 16'h0000, 2'b00, "w2z");
        read_expect(16'h0020, 16'h12FF, "r2z");

        // Contention: both valid for 8 cycles, write wins first after reset
        do_reset();
        wd_cnt  = 0;
        rsp_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            if (i < 8) begin
                wr_cmd_valid = 1'b1;
                wr_cmd_addr  = 16'h0030 + 16'(i);
                wr_cmd_data  = 16'h0100 + 16'(i);
                wr_cmd_strb  = 2'b11;
                rd_cmd_valid = 1'b1;
                rd_cmd_addr  = 16'h0010;
            end else begin
                idle();
            end
            #1;
            if (i < 8) begin
                chk($sformatf("arb_wr_rdy%0d", i), wr_cmd_ready, (i % 2 == 0));
                chk($sformatf("arb_rd_rdy%0d", i), rd_cmd_ready, (i % 2 == 1));
            end
            if (wr_done) wd_cnt++;
            if (rd_resp_valid && rd_resp_ready) begin
                chk($sformatf("arb_rsp%0d", rsp_cnt), rd_resp_data, 16'hA5A5);
                rsp_cnt++;
            end
            @(negedge clk);
        end
        chk("arb_wr_done_cnt", wd_cnt, 4);
        chk("arb_rsp_cnt", rsp_cnt, 4);

        // Backpressure: only two reads fit while the sink stalls
        t4_addr = '{16'h0030, 16'h0032, 16'h0034, 16'h0036, 16'h0010};
        t4_exp  = '{16'h0100, 16'h0102, 16'h0104, 16'h0106, 16'hA5A5};
        k   = 0;
        got = 0;
        for (int c = 0; c < 24; c++) begin
            rd_cmd_valid  = (k < 5);
            rd_cmd_addr   = t4_addr[(k < 5) ? k : 0];
            rd_resp_ready = (c >= 6);
            #1;
            if (c == 5) begin
                chk("bp_accepted", k, 2);
                chk("bp_rdy_low", rd_cmd_ready, 0);
            end
            if (rd_cmd_valid && rd_cmd_ready) k++;
            if (rd_resp_valid && rd_resp_ready) begin
                if (got < 5) chk($sformatf("bp_data%0d", got), rd_resp_data, t4_exp[got]);
                got++;
            end
            @(negedge clk);
        end
        idle();
        rd_resp_ready = 1'b1;
        chk("bp_accept_total", k, 5);
        chk("bp_resp_total", got, 5);

        // Streaming reads, one per cycle
        for (int i = 0; i < 16; i++) begin
            do_write(16'(i), pat(i), 2'b11, $sformatf("pre%0d", i));
        end
        k   = 0;
        got = 0;
        for (int c = 0; c < 22; c++) begin
            rd_cmd_valid = (c < 16);
            rd_cmd_addr  = 16'(c);
            #1;
            if (rd_cmd_valid && rd_cmd_ready) k++;
            if (rd_resp_valid && rd_resp_ready) begin
                chk($sformatf("st_cycle%0d", got), c, got + 2);
                chk($sformatf("st_data%0d", got), rd_resp_data, pat(got));
                got++;
            end
            @(negedge clk);
        end
        idle();
        chk("st_accepts", k, 16);
        chk("st_resps", got, 16);

        // Reset while a read is in flight discards it
        rd_cmd_valid = 1'b1;
        rd_cmd_addr  = 16'h0010;
        #1;
        chk("mr_rd_rdy", rd_cmd_ready, 1);
        @(negedge clk);
        rd_cmd_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mr_no_resp0", rd_resp_valid, 0);
        @(negedge clk);
        #1;
        chk("mr_no_resp1", rd_resp_valid, 0);
        chk("mr_wr_done", wr_done, 0);
        @(negedge clk);
        read_expect(16'h0020, 16'h12FF, "mr_r");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/taxi_ram_1rw_arb.md
Name: taxi_ram_1rw_arb

Overview:
- Front-end controller driving one single-port RAM (1-cycle registered read latency; read data holds until the next read).
- Accepts independent valid/ready write and read command streams.
- Arbitrates them round-robin onto the shared RAM port.
- Returns read data through a 2-entry response FIFO with full backpressure support. Sustains one RAM access per cycle.

Parameters:
- ADDR_W, 16, RAM word address width
- DATA_W, 16, data width
- STRB_W, DATA_W/8, write strobe width (one bit per byte lane)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- wr_cmd_addr  in  ADDR_W  write word address
- wr_cmd_data  in  DATA_W  write data
- wr_cmd_strb  in  STRB_W  byte-lane write enables
- wr_cmd_valid  in  1  write command valid
- wr_cmd_ready  out  1  write command accepted this cycle when high with valid
- wr_done  out  1  registered one-cycle pulse per accepted write
- rd_cmd_addr  in  ADDR_W  read word address
- rd_cmd_valid  in  1  read command valid
- rd_cmd_ready  out  1  read command accepted when high with valid
- rd_resp_data  out  DATA_W  read response data
- rd_resp_valid  out  1  response valid
- rd_resp_ready  in  1  response sink ready
- ram_en  out  1  RAM port enable
- ram_addr  out  ADDR_W  RAM address
- ram_wr_en  out  1  RAM write select
- ram_wr_data  out  DATA_W  RAM write data
- ram_wr_strb  out  STRB_W  RAM write strobes
- ram_rd_data  in  DATA_W  RAM read data, valid the cycle after a read issue

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset:
  - Response FIFO empty; rd_resp_valid=0; wr_done=0; inflight=0.
  - last_grant=READ, so write wins the first conflict.
- Read credit:
  - rd_eligible = rd_cmd_valid && (occ + inflight - pop) < 2.
  - occ = FIFO entries (0..2); inflight = read issued last cycle (0/1); pop = rd_resp_valid && rd_resp_ready.
  - This gives a combinational path rd_resp_ready -> rd_cmd_ready, which is permitted.
- Grant (combinational, per cycle):
  - Only wr_cmd_valid -> WRITE. Only rd_eligible -> READ.
  - Both -> opposite of last_grant.
  - last_grant updates only on an actual grant.
- Command handshakes:
  - wr_cmd_ready = grant==WRITE.
  - rd_cmd_ready = grant==READ.
  - Ready is never asserted without the matching valid and grant.
- RAM drive (combinational from grant):
  - ram_en = any grant; ram_wr_en = grant==WRITE.
  - ram_addr muxed from the granted command.
  - ram_wr_data/ram_wr_strb pass through wr_cmd_*.
- Write completion: wr_done pulses in cycle N+1 for a write accepted in cycle N.
- Read capture:
  - inflight register set on read accept.
  - Next cycle, ram_rd_data is pushed into the FIFO. The push is unconditional because credit guarantees space.
- Response FIFO:
  - 2-entry, in order; rd_resp_data/valid driven from the head register.
  - Push and pop in the same cycle are legal; occ is unchanged.
  - Minimum read latency: accept at N -> rd_resp_valid at N+2.
- Ordering: a write accepted at N is visible to a read accepted at N+1 or later. Same-cycle conflicts cannot occur.
- Strobe: wr_cmd_strb=0 still consumes a RAM cycle and still pulses wr_done.
- Reset mid-operation: the inflight read and FIFO contents are discarded; no response is emitted for them.
- Throughput: with rd_resp_ready=1, back-to-back reads issue every cycle. Alternating write/read contention yields 50/50 service.

Decomposition:
- No shared package is needed; the grant encoding (WRITE/READ) is a local enum.
- Natural sub-module: taxi_ram_1rw_arb_resp_fifo, a 2-entry register FIFO with push/pop/occ outputs. It is reusable elsewhere.
- Bench instantiates taxi_ram_1rw_arb with the RAM.

Test Plan:
- Write addr 0x0010 data 0xA5A5 strb 2'b11, then read 0x0010 -> wr_done at N+1; rd_resp_data=0xA5A5 at N+2 of the read accept.
- Write 0xFFFF to 0x0020, then 0x1200 strb 2'b10, then read -> response 0x12FF.
- wr_cmd_valid and rd_cmd_valid held high 8 cycles -> grants alternate W,R,W,R…; first grant WRITE after reset; 4 wr_done and 4 responses.
- rd_resp_ready=0, 5 reads queued -> exactly 2 accepted, rd_cmd_ready=0 thereafter. Raise ready -> remaining 3 drain in order with no loss or duplication.
- rd_resp_ready=1, reads to 0x0000..0x000F every cycle -> 16 accepts in 16 cycles; responses contiguous and in order.
- Assert rst one cycle after a read accept -> no rd_resp_valid afterward; next read returns correct data at N+2.
